// File: rtl/rd_weight_pkg.sv
// rd_weight_pkg: shared state encoding and width helpers for the rd_weight_seq engine
package rd_weight_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  function automatic int clog2_n1(input int n);
    return $clog2(n + 1);
  endfunction
  function automatic int nch(input int n, input int chunk);
    return (n + chunk - 1) / chunk;
  endfunction
endpackage

// File: rtl/rd_weight_seq_if.sv
// rd_weight_seq_if: request/response handshake bundle (in_valid/in_ready/in_data/in_sel, out_valid/out_ready/out_count/out_z, plus in_thresh/out_ge when RD_THRESH_EN)
interface rd_weight_seq_if #(parameter int N = 8);
  import rd_weight_pkg::*;
  localparam int CW = clog2_n1(N);
  localparam int SW = $clog2(CW) + 1;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [SW-1:0] in_sel;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_count;
  logic          out_z;
`ifdef RD_THRESH_EN
  logic [CW-1:0] in_thresh;
  logic          out_ge;
  modport master (output in_valid, in_data, in_sel, in_thresh, out_ready,
                  input in_ready, out_valid, out_count, out_z, out_ge);
  modport slave  (input in_valid, in_data, in_sel, in_thresh, out_ready,
                  output in_ready, out_valid, out_count, out_z, out_ge);
`else
  modport master (output in_valid, in_data, in_sel, out_ready,
                  input in_ready, out_valid, out_count, out_z);
  modport slave  (input in_valid, in_data, in_sel, out_ready,
                  output in_ready, out_valid, out_count, out_z);
`endif
endinterface

// File: rtl/rd_chunk_popcount.sv
// rd_chunk_popcount: combinational ones-count of one masked chunk (bits, valid_mask in; cnt out)
module rd_chunk_popcount #(parameter int CHUNK = 2) (
  input  logic [CHUNK-1:0]               bits,
  input  logic [CHUNK-1:0]               valid_mask,
  output logic [$clog2(CHUNK+1)-1:0]     cnt
);
  localparam int KW = $clog2(CHUNK + 1);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < CHUNK; i++) cnt = cnt + KW'(bits[i] & valid_mask[i]);
  end
endmodule

// File: rtl/rd_weight_seq.sv
// rd_weight_seq: multi-cycle ones-count engine folding CHUNK bits/cycle; ports clk, rst_n (async active-low), bus (rd_weight_seq_if.slave); RD_THRESH_EN adds in_thresh/out_ge
module rd_weight_seq
  import rd_weight_pkg::*;
#(
  parameter int N     = 8,
  parameter int CHUNK = 2
) (
  input logic          clk,
  input logic          rst_n,
  rd_weight_seq_if.slave bus
);
  localparam int CW  = clog2_n1(N);
  localparam int NCH = nch(N, CHUNK);
  localparam int PW  = NCH * CHUNK;
  localparam int SW  = $clog2(CW) + 1;
  localparam int IW  = NCH > 1 ? $clog2(NCH) : 1;
  localparam int KW  = $clog2(CHUNK + 1);
  // ones for real input positions, zeros for the padding of the last chunk
  localparam logic [PW-1:0] MASK = {PW{1'b1}} >> (PW - N);
  state_t        state_q;
  logic [PW-1:0] data_q;
  logic [SW-1:0] sel_q;
  logic [CW-1:0] acc_q, count_q, sum_d, shift_d;
  logic [IW-1:0] idx_q;
  logic          valid_q, z_q, accept;
  logic [KW-1:0] cnt;
`ifdef RD_THRESH_EN
  logic [CW-1:0] thresh_q;
  logic          ge_q;
`endif
  rd_chunk_popcount #(.CHUNK(CHUNK)) u_pop (
    .bits       (data_q[idx_q*CHUNK +: CHUNK]),
    .valid_mask (MASK[idx_q*CHUNK +: CHUNK]),
    .cnt        (cnt)
  );
  assign sum_d   = acc_q + CW'(cnt);
  // shifting past the count width leaves 0, which is the required out-of-range z
  assign shift_d = sum_d >> sel_q;
  assign bus.in_ready  = state_q == IDLE || (state_q == DONE && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_count = count_q;
  assign bus.out_z     = z_q;
`ifdef RD_THRESH_EN
  assign bus.out_ge    = ge_q;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      sel_q    <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      count_q  <= '0;
      z_q      <= 1'b0;
`ifdef RD_THRESH_EN
      thresh_q <= '0;
      ge_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: ;
        ACCUM: begin
          acc_q <= sum_d;
          idx_q <= idx_q + 1'b1;
          if (idx_q == IW'(NCH - 1)) begin
            count_q <= sum_d;
            z_q     <= shift_d[0];
`ifdef RD_THRESH_EN
            ge_q    <= sum_d >= thresh_q;
`endif
            valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // an accept overrides the DONE->IDLE step so back-to-back requests lose no cycle
      if (accept) begin
        data_q   <= PW'(bus.in_data);
        sel_q    <= bus.in_sel;
`ifdef RD_THRESH_EN
        thresh_q <= bus.in_thresh;
`endif
        acc_q    <= '0;
        idx_q    <= '0;
        state_q  <= ACCUM;
      end
    end
  end
endmodule

// File: tb/tb_rd_weight_seq.sv
// tb_rd_weight_seq: directed self-checking bench for rd_weight_seq (N=8/CHUNK=2 and N=5/CHUNK=2 instances)
module tb_rd_weight_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  rd_weight_seq_if #(.N(8)) a ();
  rd_weight_seq_if #(.N(5)) b ();
  rd_weight_seq #(.N(8), .CHUNK(2)) dut  (.clk(clk), .rst_n(rst_n), .bus(a.slave));
  rd_weight_seq #(.N(5), .CHUNK(2)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b.slave));

  task automatic req(input logic [7:0] d, input logic [2:0] s);
    a.in_valid = 1'b1;
    a.in_data  = d;
    a.in_sel   = s;
    @(posedge clk);
    #1 a.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (a.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic drain;
    a.out_ready = 1'b1;
    @(posedge clk);
    #1 a.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_vec++; if (a.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", a.out_valid); end
    n_vec++; if (a.out_count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", a.out_count); end
    n_vec++; if (a.out_z !== 1'b0) begin n_err++; $display("FAIL reset_z: got %b expected 0", a.out_z); end
    n_vec++; if (a.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", a.in_ready); end
`ifdef RD_THRESH_EN
    n_vec++; if (a.out_ge !== 1'b0) begin n_err++; $display("FAIL reset_ge: got %b expected 0", a.out_ge); end
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    int lat;
    req(8'hB5, 3'd0);
    wait_out(lat);
    n_vec++; if (lat != 4) begin n_err++; $display("FAIL basic_latency: got %0d expected 4", lat); end
    n_vec++; if (a.out_count !== 4'd5) begin n_err++; $display("FAIL basic_count: got %0d expected 5", a.out_count); end
    n_vec++; if (a.out_z !== 1'b1) begin n_err++; $display("FAIL basic_z: got %b expected 1", a.out_z); end
    drain;
    n_vec++; if (a.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drop: got %b expected 0", a.out_valid); end
    n_vec++; if (a.out_count !== 4'd5) begin n_err++; $display("FAIL basic_retain: got %0d expected 5", a.out_count); end
    n_vec++; if (a.in_ready !== 1'b1) begin n_err++; $display("FAIL basic_idle_ready: got %b expected 1", a.in_ready); end
  endtask

  task automatic test_extremes;
    int lat;
    req(8'h00, 3'd0);
    wait_out(lat);
    n_vec++; if (a.out_count !== 4'd0) begin n_err++; $display("FAIL zero_count: got %0d expected 0", a.out_count); end
    n_vec++; if (a.out_z !== 1'b0) begin n_err++; $display("FAIL zero_z: got %b expected 0", a.out_z); end
    drain;
    req(8'hFF, 3'd3);
    wait_out(lat);
    n_vec++; if (a.out_count !== 4'd8) begin n_err++; $display("FAIL full_count: got %0d expected 8", a.out_count); end
    n_vec++; if (a.out_z !== 1'b1) begin n_err++; $display("FAIL full_z_sel3: got %b expected 1", a.out_z); end
    drain;
    req(8'hFF, 3'd7);
    wait_out(lat);
    n_vec++; if (a.out_count !== 4'd8) begin n_err++; $display("FAIL full_count2: got %0d expected 8", a.out_count); end
    n_vec++; if (a.out_z !== 1'b0) begin n_err++; $display("FAIL full_z_sel7: got %b expected 0", a.out_z); end
    drain;
  endtask

  task automatic test_back_to_back;
    int lat;
    req(8'h3C, 3'd2);
    wait_out(lat);
    n_vec++; if (lat != 4) begin n_err++; $display("FAIL bp_latency: got %0d expected 4", lat); end
    n_vec++; if (a.out_z !== 1'b1) begin n_err++; $display("FAIL bp_z: got %b expected 1", a.out_z); end
    for (int i = 0; i < 6; i++) begin
      a.in_valid = (i % 2 == 0);
      a.in_data  = 8'hFF;
      #1;
      n_vec++; if (a.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, a.in_ready); end
      n_vec++; if (a.out_valid !== 1'b1 || a.out_count !== 4'd4) begin n_err++; $display("FAIL bp_hold[%0d]: got valid=%b count=%0d expected valid=1 count=4", i, a.out_valid, a.out_count); end
      @(posedge clk);
      #1;
    end
    a.in_valid = 1'b0;
    n_vec++; if (a.out_valid !== 1'b1 || a.out_count !== 4'd4) begin n_err++; $display("FAIL bp_final: got valid=%b count=%0d expected valid=1 count=4", a.out_valid, a.out_count); end
    a.out_ready = 1'b1;
    a.in_valid  = 1'b1;
    a.in_data   = 8'h01;
    a.in_sel    = 3'd0;
    #1;
    n_vec++; if (a.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b expected 1", a.in_ready); end
    @(posedge clk);
    #1 a.in_valid = 1'b0;
    a.out_ready = 1'b0;
    n_vec++; if (a.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drop: got %b expected 0", a.out_valid); end
    wait_out(lat);
    n_vec++; if (lat != 4) begin n_err++; $display("FAIL b2b_latency: got %0d expected 4", lat); end
    n_vec++; if (a.out_count !== 4'd1 || a.out_z !== 1'b1) begin n_err++; $display("FAIL b2b_result: got count=%0d z=%b expected count=1 z=1", a.out_count, a.out_z); end
    drain;
  endtask

  task automatic test_reset_mid;
    int lat;
    req(8'hAA, 3'd0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if (a.out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b expected 0", a.out_valid); end
    n_vec++; if (a.out_count !== 4'd0) begin n_err++; $display("FAIL rmid_count: got %0d expected 0", a.out_count); end
    n_vec++; if (a.in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready: got %b expected 1", a.in_ready); end
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    req(8'h0F, 3'd0);
    wait_out(lat);
    n_vec++; if (lat != 4) begin n_err++; $display("FAIL rmid_latency: got %0d expected 4", lat); end
    n_vec++; if (a.out_count !== 4'd4 || a.out_z !== 1'b0) begin n_err++; $display("FAIL rmid_result: got count=%0d z=%b expected count=4 z=0", a.out_count, a.out_z); end
    drain;
  endtask

  task automatic test_pad;
    int lat;
    logic [4:0] d [2] = '{5'b10111, 5'b11111};
    logic [2:0] s [2] = '{3'd2, 3'd3};
    logic [2:0] c [2] = '{3'd4, 3'd5};
    logic       z [2] = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      b.in_valid = 1'b1;
      b.in_data  = d[k];
      b.in_sel   = s[k];
      @(posedge clk);
      #1 b.in_valid = 1'b0;
      lat = 0;
      while (b.out_valid !== 1'b1 && lat < 20) begin
        @(posedge clk);
        #1 lat++;
      end
      n_vec++; if (lat != 3) begin n_err++; $display("FAIL pad_latency[%0d]: got %0d expected 3", k, lat); end
      n_vec++; if (b.out_count !== c[k] || b.out_z !== z[k]) begin n_err++; $display("FAIL pad_result[%0d]: got count=%0d z=%b expected count=%0d z=%b", k, b.out_count, b.out_z, c[k], z[k]); end
      b.out_ready = 1'b1;
      @(posedge clk);
      #1 b.out_ready = 1'b0;
    end
  endtask

`ifdef RD_THRESH_EN
  task automatic test_thresh;
    int lat;
    logic [3:0] t [3] = '{4'd4, 4'd5, 4'd0};
    logic       g [3] = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      a.in_thresh = t[k];
      req(8'h0F, 3'd0);
      wait_out(lat);
      n_vec++; if (a.out_ge !== g[k]) begin n_err++; $display("FAIL thresh_ge[%0d]: got %b expected %b", k, a.out_ge, g[k]); end
      drain;
    end
  endtask
`endif

  initial begin
    a.in_valid = 1'b0; a.in_data = '0; a.in_sel = '0; a.out_ready = 1'b0;
    b.in_valid = 1'b0; b.in_data = '0; b.in_sel = '0; b.out_ready = 1'b0;
`ifdef RD_THRESH_EN
    a.in_thresh = '0;
    b.in_thresh = '0;
`endif
    test_reset;
    test_basic;
    test_extremes;
    test_back_to_back;
    test_reset_mid;
    test_pad;
`ifdef RD_THRESH_EN
    test_thresh;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
